// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control definitions: FSM encoding,
// register-zero constant and default operand widths.
package pipe_ctrl_pkg;

  localparam int DEF_REG_ADDR_W = 5;
  localparam int REG_ZERO       = 0;

  localparam logic ST_RUN    = 1'b0;
  localparam logic ST_LSTALL = 1'b1;

  typedef enum logic {
    S_RUN    = ST_RUN,
    S_LSTALL = ST_LSTALL
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic haz_mux;
    logic pipe_en;
    logic stalling;
  } ctrl_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear;
// clear wins over a same-cycle increment.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Load-use hazard detector with multi-cycle stall,
// branch flush, debug freeze and stall-cycle counter.
module hazard_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = DEF_REG_ADDR_W,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] i_id_rs,
  input  logic [REG_ADDR_W-1:0] i_id_rt,
  input  logic                  i_id_uses_rs,
  input  logic                  i_id_uses_rt,
  input  logic [REG_ADDR_W-1:0] i_ex_rt,
  input  logic                  i_ex_mem_read,
  input  logic                  i_branch_taken,
  input  logic                  i_halt,
  input  logic                  i_cnt_clr,
  output logic                  o_pc_write,
  output logic                  o_ifid_write,
  output logic                  o_ifid_flush,
  output logic                  o_haz_mux,
  output logic                  o_pipe_en,
  output logic                  o_stalling,
  output logic [CNT_W-1:0]      o_stall_cnt
);

  localparam logic [3:0] REM_INIT = 4'(LOAD_STALL - 1);

  state_e     state_q;
  state_e     state_d;
  logic [3:0] rem_q;
  logic [3:0] rem_d;
  logic       stall_q;
  logic       stall_d;
  logic       ex_nz;
  logic       rs_hit;
  logic       rt_hit;
  logic       haz;
  ctrl_t      ctrl;

  assign ex_nz  = (i_ex_rt != REG_ADDR_W'(REG_ZERO));
  assign rs_hit = i_id_uses_rs && (i_ex_rt == i_id_rs);
  assign rt_hit = i_id_uses_rt && (i_ex_rt == i_id_rt);
  assign haz    = i_ex_mem_read && ex_nz && (rs_hit || rt_hit);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    stall_d = stall_q;
    ctrl    = '0;
    priority case (1'b1)
      !rst_n: begin
        ctrl = '0;
      end
      i_halt: begin
        // freeze: state, rem and stall flag all hold
        ctrl.stalling = stall_q;
      end
      (state_q == S_LSTALL) || haz: begin
        ctrl.pipe_en  = 1'b1;
        ctrl.haz_mux  = 1'b1;
        ctrl.stalling = 1'b1;
        stall_d       = 1'b1;
        if (state_q == S_LSTALL) begin
          rem_d = rem_q - 4'd1;
          if (rem_q == 4'd1) begin
            state_d = S_RUN;
          end
        end else if (LOAD_STALL > 1) begin
          state_d = S_LSTALL;
          rem_d   = REM_INIT;
        end
      end
      default: begin
        ctrl.pipe_en    = 1'b1;
        ctrl.pc_write   = 1'b1;
        ctrl.ifid_write = 1'b1;
        ctrl.ifid_flush = i_branch_taken;
        stall_d         = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_RUN;
      rem_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      stall_q <= stall_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_cnt (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clr_i  (i_cnt_clr),
    .inc_i  (ctrl.haz_mux),
    .cnt_o  (o_stall_cnt)
  );

  assign o_pc_write   = ctrl.pc_write;
  assign o_ifid_write = ctrl.ifid_write;
  assign o_ifid_flush = ctrl.ifid_flush;
  assign o_haz_mux    = ctrl.haz_mux;
  assign o_pipe_en    = ctrl.pipe_en;
  assign o_stalling   = ctrl.stalling;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: three parameterisations
// checked against a remaining-bubbles reference model.
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       uses_rs, uses_rt, mem_rd;
  logic       br, halt, clr;

  logic pcw [3];
  logic ifw [3];
  logic fl  [3];
  logic hm  [3];
  logic pe  [3];
  logic st  [3];
  logic [15:0] c0, c1;
  logic [1:0]  c2;

  int checks = 0;
  int errors = 0;

  int m_ls   [3] = '{1, 3, 3};
  int m_cmax [3] = '{65535, 65535, 3};
  int m_left [3] = '{0, 0, 0};
  int m_cnt  [3] = '{0, 0, 0};
  bit m_last [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.REG_ADDR_W(5), .LOAD_STALL(1), .CNT_W(16)) u_d0 (
    .clk(clk), .rst_n(rst_n), .i_id_rs(id_rs), .i_id_rt(id_rt),
    .i_id_uses_rs(uses_rs), .i_id_uses_rt(uses_rt), .i_ex_rt(ex_rt),
    .i_ex_mem_read(mem_rd), .i_branch_taken(br), .i_halt(halt),
    .i_cnt_clr(clr), .o_pc_write(pcw[0]), .o_ifid_write(ifw[0]),
    .o_ifid_flush(fl[0]), .o_haz_mux(hm[0]), .o_pipe_en(pe[0]),
    .o_stalling(st[0]), .o_stall_cnt(c0));

  hazard_ctrl_unit #(.REG_ADDR_W(5), .LOAD_STALL(3), .CNT_W(16)) u_d1 (
    .clk(clk), .rst_n(rst_n), .i_id_rs(id_rs), .i_id_rt(id_rt),
    .i_id_uses_rs(uses_rs), .i_id_uses_rt(uses_rt), .i_ex_rt(ex_rt),
    .i_ex_mem_read(mem_rd), .i_branch_taken(br), .i_halt(halt),
    .i_cnt_clr(clr), .o_pc_write(pcw[1]), .o_ifid_write(ifw[1]),
    .o_ifid_flush(fl[1]), .o_haz_mux(hm[1]), .o_pipe_en(pe[1]),
    .o_stalling(st[1]), .o_stall_cnt(c1));

  hazard_ctrl_unit #(.REG_ADDR_W(5), .LOAD_STALL(3), .CNT_W(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .i_id_rs(id_rs), .i_id_rt(id_rt),
    .i_id_uses_rs(uses_rs), .i_id_uses_rt(uses_rt), .i_ex_rt(ex_rt),
    .i_ex_mem_read(mem_rd), .i_branch_taken(br), .i_halt(halt),
    .i_cnt_clr(clr), .o_pc_write(pcw[2]), .o_ifid_write(ifw[2]),
    .o_ifid_flush(fl[2]), .o_haz_mux(hm[2]), .o_pipe_en(pe[2]),
    .o_stalling(st[2]), .o_stall_cnt(c2));

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit m_haz();
    return mem_rd && (ex_rt != 0) &&
           ((uses_rs && ex_rt == id_rs) || (uses_rt && ex_rt == id_rt));
  endfunction

  function automatic bit m_bubble(int k);
    return rst_n && !halt && (m_left[k] > 0 || m_haz());
  endfunction

  // {pc_write, ifid_write, flush, haz_mux, pipe_en, stalling}
  function automatic logic [5:0] m_out(int k);
    if (!rst_n) return 6'b000000;
    if (halt) return {5'b00000, m_last[k]};
    if (m_bubble(k)) return 6'b000111;
    return {2'b11, br, 3'b010};
  endfunction

  function automatic logic [15:0] dut_cnt(int k);
    if (k == 0) return c0;
    if (k == 1) return c1;
    return {14'd0, c2};
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      logic [5:0] e;
      e = m_out(k);
      chk($sformatf("pc_write%0d", k), pcw[k], e[5]);
      chk($sformatf("ifid_write%0d", k), ifw[k], e[4]);
      chk($sformatf("ifid_flush%0d", k), fl[k], e[3]);
      chk($sformatf("haz_mux%0d", k), hm[k], e[2]);
      chk($sformatf("pipe_en%0d", k), pe[k], e[1]);
      chk($sformatf("stalling%0d", k), st[k], e[0]);
      chk($sformatf("stall_cnt%0d", k), dut_cnt(k), 16'(m_cnt[k]));
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      bit b;
      b = m_bubble(k);
      if (!rst_n) begin
        m_left[k] = 0;
        m_cnt[k]  = 0;
        m_last[k] = 0;
      end else begin
        if (clr) m_cnt[k] = 0;
        else if (b && m_cnt[k] < m_cmax[k]) m_cnt[k] = m_cnt[k] + 1;
        if (!halt) begin
          if (m_left[k] > 0) m_left[k] = m_left[k] - 1;
          else if (m_haz()) m_left[k] = m_ls[k] - 1;
          m_last[k] = b;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs = 5'd1; id_rt = 5'd2; ex_rt = 5'd3;
    uses_rs = 1'b0; uses_rt = 1'b0; mem_rd = 1'b0;
    br = 1'b0; halt = 1'b0; clr = 1'b0;
  endtask

  task automatic hazard();
    mem_rd = 1'b1; ex_rt = 5'd8; id_rs = 5'd8; uses_rs = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    repeat (3) tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cnt", c1, 16'd0);
    chk("rst_pc_write", pcw[0], 1'b1);

    tick(); hazard();
    @(negedge clk);
    chk("ls1_haz_mux", hm[0], 1'b1);
    chk("ls1_pc_write", pcw[0], 1'b0);
    chk("ls3_haz_mux_b1", hm[1], 1'b1);
    tick(); idle();
    @(negedge clk);
    chk("ls1_release", pcw[0], 1'b1);
    chk("ls3_haz_mux_b2", hm[1], 1'b1);
    tick();
    @(negedge clk);
    chk("ls3_haz_mux_b3", hm[1], 1'b1);
    tick();
    @(negedge clk);
    chk("ls3_done", pcw[1], 1'b1);
    chk("ls1_cnt", c0, 16'd1);
    chk("ls3_cnt", c1, 16'd3);

    tick(); mem_rd = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; uses_rs = 1'b1;
    @(negedge clk);
    chk("zero_reg", hm[1], 1'b0);
    tick(); idle(); mem_rd = 1'b1; ex_rt = 5'd9; id_rt = 5'd9;
    @(negedge clk);
    chk("unused_rt", hm[1], 1'b0);

    tick(); idle(); clr = 1'b1;
    tick(); clr = 1'b0;
    @(negedge clk);
    chk("clr_cnt", c1, 16'd0);

    tick(); hazard();
    tick(); idle(); halt = 1'b1;
    @(negedge clk);
    chk("halt_pipe_en", pe[1], 1'b0);
    chk("halt_haz_mux", hm[1], 1'b0);
    chk("halt_stalling", st[1], 1'b1);
    tick();
    @(negedge clk);
    chk("halt_cnt_frozen", c1, 16'd1);
    tick(); halt = 1'b0;
    @(negedge clk);
    chk("resume_b2", hm[1], 1'b1);
    tick();
    tick();
    @(negedge clk);
    chk("resume_done", hm[1], 1'b0);
    chk("halt_total", c1, 16'd3);

    tick(); hazard(); br = 1'b1;
    @(negedge clk);
    chk("br_in_stall", fl[1], 1'b0);
    chk("br_in_stall_ls1", fl[0], 1'b0);
    tick(); idle();
    tick();
    tick(); br = 1'b1;
    @(negedge clk);
    chk("br_flush", fl[1], 1'b1);
    chk("br_pc_write", pcw[1], 1'b1);
    tick(); idle();
    @(negedge clk);
    chk("sat_cnt", {14'd0, c2}, 16'd3);
    chk("ls3_cnt6", c1, 16'd6);
    chk("ls1_cnt2", c0, 16'd2);

    tick(); hazard(); clr = 1'b1;
    tick(); idle();
    @(negedge clk);
    chk("clr_vs_inc", c0, 16'd0);
    tick();
    tick();

    tick(); hazard();
    tick(); idle(); rst_n = 1'b0;
    @(negedge clk);
    chk("rst_pipe_en", pe[1], 1'b0);
    tick(); rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_run", hm[1], 1'b0);
    chk("post_rst_cnt", c1, 16'd0);

    for (int n = 0; n < 3000; n++) begin
      tick();
      rst_n   = ($urandom_range(0, 63) != 0);
      halt    = ($urandom_range(0, 9) == 0);
      clr     = ($urandom_range(0, 19) == 0);
      br      = ($urandom_range(0, 3) == 0);
      mem_rd  = ($urandom_range(0, 1) == 0);
      uses_rs = ($urandom_range(0, 2) != 0);
      uses_rt = ($urandom_range(0, 2) != 0);
      id_rs   = 5'($urandom_range(0, 3));
      id_rt   = 5'($urandom_range(0, 3));
      ex_rt   = 5'($urandom_range(0, 3));
    end
    tick(); idle(); rst_n = 1'b1;
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
- Parametrised successor to the pipeline's load-use hazard detector for the 5-stage MIPS core.
- Features:
  - Generalised register-address width.
  - Configurable load-use stall length, for multi-cycle data memory.
  - Operand-use qualification and $zero filtering.
  - Branch flush control.
  - Debug-unit freeze.
  - Saturating stall-cycle counter.
- Sits between ID and EX. Drives PC write enable, IF/ID write and flush, the ID/EX bubble mux, and the global pipeline enable.

Parameters:
- REG_ADDR_W, 5, width of register specifiers.
- LOAD_STALL, 1, bubble cycles inserted per load-use hazard (1..15).
- CNT_W, 16, width of the stall-cycle performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- i_id_rs  in  REG_ADDR_W  rs of instruction in ID.
- i_id_rt  in  REG_ADDR_W  rt of instruction in ID.
- i_id_uses_rs  in  1  ID instruction reads rs.
- i_id_uses_rt  in  1  ID instruction reads rt.
- i_ex_rt  in  REG_ADDR_W  destination rt of instruction in EX.
- i_ex_mem_read  in  1  EX instruction is a load.
- i_branch_taken  in  1  branch/jump resolved taken in ID.
- i_halt  in  1  debug-unit freeze request.
- i_cnt_clr  in  1  clear the stall counter.
- o_pc_write  out  1  PC write enable.
- o_ifid_write  out  1  IF/ID register write enable.
- o_ifid_flush  out  1  IF/ID register loads NOP.
- o_haz_mux  out  1  ID/EX control fields forced to zero (bubble).
- o_pipe_en  out  1  global stage enable, 0 = freeze all stages.
- o_stalling  out  1  load-use stall in progress.
- o_stall_cnt  out  CNT_W  saturating count of bubble cycles.

Behaviour:
- Reset:
  - Synchronous, active-low: rst_n sampled low at a rising clk edge resets the block.
  - Reset state: state=RUN, rem=0, o_stall_cnt=0.
  - While rst_n=0 all outputs are forced: o_pc_write=0, o_ifid_write=0, o_ifid_flush=0, o_haz_mux=0, o_pipe_en=0, o_stalling=0.
  - Reset mid-stall aborts the stall; first cycle after release is RUN.
- Hazard condition:
  - haz = i_ex_mem_read && i_ex_rt!=0 && ((i_id_uses_rs && i_ex_rt==i_id_rs) || (i_id_uses_rt && i_ex_rt==i_id_rt)).
  - haz is combinational, same cycle; no input registering.
- States: RUN, LSTALL. rem is a 4-bit down-counter.
- RUN, no halt, haz=1:
  - Outputs: o_pc_write=0, o_ifid_write=0, o_haz_mux=1, o_stalling=1, o_ifid_flush=0.
  - If LOAD_STALL>1: next state LSTALL with rem=LOAD_STALL-1.
  - If LOAD_STALL=1: remain in RUN (legacy single-bubble behaviour).
- LSTALL, no halt:
  - Outputs identical to RUN with haz=1, regardless of inputs.
  - rem decrements each cycle; when rem==1, next state RUN.
  - Total bubbles per hazard = LOAD_STALL exactly.
- RUN, no halt, haz=0:
  - Outputs: o_pc_write=1, o_ifid_write=1, o_haz_mux=0, o_stalling=0.
  - o_ifid_flush = i_branch_taken.
- Priority: reset > halt > stall (haz or LSTALL) > branch flush > run.
  - i_branch_taken is ignored while stalling, because the ID branch operands are not yet valid. The branch is re-evaluated after the stall.
- Halt (i_halt=1, any state):
  - Outputs: o_pipe_en=0, o_pc_write=0, o_ifid_write=0, o_haz_mux=0, o_ifid_flush=0.
  - state and rem are frozen; o_stalling holds its pre-halt value.
  - Halt is a freeze, not a bubble.
  - On halt release, the stall resumes with the remaining count.
- o_pipe_en = 1 whenever rst_n=1 and i_halt=0.
- Counter:
  - o_stall_cnt increments by 1 at each edge where o_haz_mux=1.
  - Saturates at 2^CNT_W-1.
  - i_cnt_clr forces 0 and takes precedence over a same-cycle increment.
- No $display or other simulation-only statements in RTL.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - State encoding localparams ST_RUN=1'b0, ST_LSTALL=1'b1.
  - REG_ZERO constant.
  - Default REG_ADDR_W.
- One natural sub-module: sat_counter (parametrised CNT_W; inc, clr, saturating), reused later for other performance counters.
- Hazard compare and FSM stay in the top.

Test Plan:
- LOAD_STALL=1; ex_mem_read=1, ex_rt=8, id_rs=8, uses_rs=1 for one cycle -> exactly one cycle of pc_write=0, ifid_write=0, haz_mux=1; o_stall_cnt=1.
- LOAD_STALL=3; same hazard, inputs de-asserted after cycle 1 -> haz_mux=1 for exactly 3 cycles, then pc_write=1; o_stall_cnt=3.
- ex_rt=0 matching id_rs=0 with ex_mem_read=1, and ex_rt=9=id_rt with uses_rt=0 -> no stall in either case.
- LOAD_STALL=3; halt asserted for 2 cycles during the second stall cycle -> pipe_en=0, haz_mux=0, counter frozen for those 2 cycles; stall then completes. Total bubbles 3, o_stall_cnt=3.
- branch_taken=1 concurrent with a hazard -> flush=0, stall taken. Branch_taken=1 in RUN without a hazard -> ifid_flush=1 for 1 cycle, pc_write=1.
- CNT_W=2: 5 stall cycles -> counter saturates at 3. cnt_clr concurrent with a bubble -> 0. rst_n=0 mid-LSTALL -> next cycle RUN, all counts 0.
